gate_tester: RTL and testbench
==============================

Name: gate_tester

Overview:
- Sequential stimulus driver and response checker for a 2^N_IN-row combinational gate, such as nand_gate.
- On start, it sweeps every input vector into the device under test (DUT) in ascending order and waits a fixed settle time per vector.
- It samples the DUT output and compares it against a truth-table parameter.
- It reports an error count, the first failing vector, and a pass/done status.
- It sits beside the gate library as the self-checking counterpart that consumes gate outputs.

Parameters:
- N_IN, 2, number of DUT inputs; sweeps 2^N_IN vectors.
- SETTLE, 2, extra wait cycles per vector before sampling (>= 0).
- EXPECT, 4'b0111, expected output per vector; bit i is the expected y for vec_out == i (the default is the NAND truth table). Width is 2^N_IN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- vec_out  output  N_IN  DUT input vector; vec_out[N_IN-1] maps to a, vec_out[0] to b.
- dut_y  input  1  DUT output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  level; high from sweep completion until the next start or rst.
- pass  output  1  valid when done: 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
- fail_valid  output  1  sticky; set on the first mismatch of a sweep.
- fail_vec  output  N_IN  vector of the first mismatch; holds while fail_valid = 1.

Behaviour:
- Reset (synchronous, rst high at the edge) forces state IDLE and sets all outputs to 0: vec_out=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
  - rst has priority over everything, including mid-sweep; the sweep is abandoned with no partial result.
- States:
  - IDLE: outputs at reset values. start=1 -> RUN.
  - RUN: drives the vectors and samples each one (see below).
  - DONE: busy=0, done=1, results held. start=1 -> RUN.
- Entering RUN from IDLE or DONE (edge where start=1):
  - busy=1, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, vec_out=0, settle counter=0.
- RUN timing:
  - Each vector is held on vec_out for exactly SETTLE+1 cycles.
  - dut_y is sampled at the final edge of that window, i.e. when the settle counter == SETTLE.
- At each sample:
  - Mismatch if dut_y != EXPECT[vec_out]. In simulation, an X or Z on dut_y also counts as a mismatch, using case inequality.
  - On a mismatch, err_count increments.
  - If fail_valid = 0 at a mismatch, fail_valid <= 1 and fail_vec <= vec_out.
  - If vec_out != 2^N_IN-1: vec_out increments and the settle counter resets to 0.
  - If vec_out == 2^N_IN-1: move to DONE, with busy=0, done=1, and pass computed from the final err_count, including the last sample.
  - vec_out holds its last value in DONE.
- Latency:
  - busy is high for exactly 2^N_IN*(SETTLE+1) cycles.
  - done rises on the edge after the last sample window.
  - With the defaults, that is 12 cycles.
- Arithmetic and widths:
  - err_count saturation is never needed; its maximum is 2^N_IN, which fits in N_IN+1 bits.
  - The settle counter width is clog2(SETTLE+1), minimum 1.
- start in RUN is ignored. start held high continuously causes an immediate restart on the cycle after DONE is entered, so done is high for one cycle.
- dut_y is used only on sample edges; its value in other cycles is don't-care.

Decomposition:
- Package gate_tester_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the NAND/AND/OR/XOR 2-input truth-table constants (4'b0111, 4'b1000, 4'b1110, 4'b0110) for EXPECT.
- One natural sub-module, gate_tester_ctr: a combined vector/settle counter with clear, enable, last_sample, and last_vector outputs.
- The FSM and result registers stay in gate_tester.

Test Plan:
- rst 2 cycles, then a start pulse, with nand_gate as DUT and defaults -> vec_out 0,1,2,3, each held 3 cycles; busy high 12 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- DUT is an AND gate, EXPECT=4'b0111 -> all vectors mismatch; err_count=4, fail_valid=1, fail_vec=0, pass=0.
- DUT output stuck at 1 -> only vector 3 mismatches; err_count=1, fail_vec=3, pass=0.
- Pulse start at busy cycles 3 and 7 (ignored, no change in the 12-cycle sweep). After done, start again -> done drops the next cycle, results clear, and a full 12-cycle sweep repeats.
- rst asserted while vec_out=2 -> on the next edge all outputs are 0 and state is IDLE. A subsequent start runs a full 12-cycle sweep from vector 0.
- SETTLE=0 with nand_gate -> each vector is held 1 cycle; busy for 4 cycles; pass=1. With N_IN=3, SETTLE=0, and an 8-bit EXPECT -> busy for 8 cycles, err_count width 4.

Source files
------------

// File: rtl/gate_tester_pkg.sv
// Shared types and 2-input truth tables for the gate sweep tester.
package gate_tester_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bit i is the expected gate output for input vector i (a = bit 1, b = bit 0).
    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/gate_tester_if.sv
// Control, stimulus and result signals between the tester and its environment.
interface gate_tester_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            fail_valid;
    logic [N_IN-1:0] fail_vec;

    modport master (
        output start, dut_y,
        input  vec_out, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, dut_y,
        output vec_out, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/gate_tester_ctr.sv
// Vector/settle counter: each vector is held for SETTLE+1 enabled cycles,
// and the vector holds at its maximum once the sweep completes.
module gate_tester_ctr #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    output logic [N_IN-1:0] vec,
    output logic            last_sample,
    output logic            last_vector
);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   SETTLE_MAX = SW'(SETTLE);
    localparam logic [N_IN-1:0] VEC_MAX    = '1;

    logic [N_IN-1:0] vec_reg;
    logic [SW-1:0]   settle_reg;

    assign vec         = vec_reg;
    assign last_sample = (settle_reg == SETTLE_MAX);
    assign last_vector = (vec_reg == VEC_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_reg    <= '0;
            settle_reg <= '0;
        end else if (enable) begin
            if (last_sample) begin
                settle_reg <= '0;
                if (!last_vector) begin
                    vec_reg <= vec_reg + 1'b1;
                end
            end else begin
                settle_reg <= settle_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_tester.sv
// Sweeps all input vectors of a combinational gate, compares its output
// against the EXPECT truth table and reports error count and first failure.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = NAND_TT
) (
    input logic         clk,
    input logic         rst,
    gate_tester_if.slave bus
);
    state_t          state_reg, state_next;
    logic            ctr_clear, ctr_enable;
    logic            last_sample, last_vector;
    logic [N_IN-1:0] vec;
    logic [N_IN:0]   err_count_reg;
    logic            fail_valid_reg;
    logic [N_IN-1:0] fail_vec_reg;
    logic            sample, mismatch;

    gate_tester_ctr #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .clear       (ctr_clear),
        .enable      (ctr_enable),
        .vec         (vec),
        .last_sample (last_sample),
        .last_vector (last_vector)
    );

    // Case inequality so an X/Z response is reported as a failure in simulation.
    assign mismatch = (bus.dut_y !== EXPECT[vec]);
    assign sample   = (state_reg == RUN) && last_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ctr_clear  = 1'b0;
        ctr_enable = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    ctr_clear  = 1'b1;
                end
            end
            RUN: begin
                ctr_enable = 1'b1;
                if (last_sample && last_vector) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || ctr_clear) begin
            err_count_reg  <= '0;
            fail_valid_reg <= 1'b0;
            fail_vec_reg   <= '0;
        end else if (sample && mismatch) begin
            err_count_reg <= err_count_reg + 1'b1;
            if (!fail_valid_reg) begin
                fail_valid_reg <= 1'b1;
                fail_vec_reg   <= vec;
            end
        end
    end

    assign bus.vec_out    = vec;
    assign bus.busy       = (state_reg == RUN);
    assign bus.done       = (state_reg == DONE);
    assign bus.pass       = (state_reg == DONE) && (err_count_reg == '0);
    assign bus.err_count  = err_count_reg;
    assign bus.fail_valid = fail_valid_reg;
    assign bus.fail_vec   = fail_vec_reg;

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: three instances (default, SETTLE=0, N_IN=3).
module tb_gate_tester;
    import gate_tester_pkg::*;

    typedef struct {
        int err;
        bit fv;
        int fvec;
        bit pass;
        int cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   mode_a, mode_b, mode_c;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gate_tester_if #(.N_IN(2)) ia ();
    gate_tester_if #(.N_IN(2)) ib ();
    gate_tester_if #(.N_IN(3)) ic ();

    // Behavioural gates standing in for the device under test.
    function automatic logic gate2(int mode, logic [1:0] v);
        case (mode)
            0:       return ~(v[1] & v[0]);
            1:       return v[1] & v[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic gate3(int mode, logic [2:0] v);
        if (mode == 0) return ^v;
        return ~^v;
    endfunction

    function automatic exp_t model(int n, int settle, logic [7:0] tt, logic [7:0] ys);
        exp_t e;
        e.err = 0; e.fv = 0; e.fvec = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (ys[v] != tt[v]) begin
                e.err++;
                if (!e.fv) begin
                    e.fv = 1;
                    e.fvec = v;
                end
            end
        end
        e.pass   = (e.err == 0);
        e.cycles = (1 << n) * (settle + 1);
        return e;
    endfunction

    assign ia.dut_y = gate2(mode_a, ia.vec_out);
    assign ib.dut_y = gate2(mode_b, ib.vec_out);
    assign ic.dut_y = gate3(mode_c, ic.vec_out);

    gate_tester #(.N_IN(2), .SETTLE(2), .EXPECT(NAND_TT)) dut_a (
        .clk (clk), .rst (rst), .bus (ia.slave)
    );
    gate_tester #(.N_IN(2), .SETTLE(0), .EXPECT(NAND_TT)) dut_b (
        .clk (clk), .rst (rst), .bus (ib.slave)
    );
    gate_tester #(.N_IN(3), .SETTLE(0), .EXPECT(8'h96)) dut_c (
        .clk (clk), .rst (rst), .bus (ic.slave)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ia.vec_out, ia.busy, ia.done, ia.pass, ia.err_count, ia.fail_valid, ia.fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b fvec=%0d required all 0",
                     ia.vec_out, ia.busy, ia.done, ia.pass, ia.err_count, ia.fail_valid, ia.fail_vec);
        end
        n_checks++;
        if ({ib.busy, ib.done, ic.busy, ic.done, ic.err_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_bc: busy/done/err not 0 (b %b%b c %b%b %0d)",
                     ib.busy, ib.done, ic.busy, ic.done, ic.err_count);
        end
        $display("reset: outputs checked");
        rst = 1'b0;
    endtask

    // Full sweep on the default instance; optionally pulse start mid-sweep.
    task automatic run_a(input int mode, input bit pulse, input string name);
        logic [7:0] ys;
        exp_t e;
        int cyc, vbad;
        mode_a = mode;
        ys = '0;
        for (int v = 0; v < 4; v++) ys[v] = gate2(mode, 2'(v));
        sb.push_back(model(2, 2, 8'(NAND_TT), ys));
        @(negedge clk);
        ia.start = 1'b1;
        @(posedge clk);
        #1 ia.start = 1'b0;
        n_checks++;
        if (ia.busy !== 1'b1 || ia.done !== 1'b0 || ia.err_count !== '0 || ia.fail_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b done=%b err=%0d fv=%b required 1 0 0 0",
                     name, ia.busy, ia.done, ia.err_count, ia.fail_valid);
        end
        cyc = 0; vbad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ia.busy) break;
            if (ia.vec_out !== 2'(cyc / 3)) vbad++;
            cyc++;
            if (pulse && (cyc == 3 || cyc == 7)) begin
                ia.start = 1'b1;
                @(posedge clk);
                #1 ia.start = 1'b0;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc != e.cycles) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, cyc, e.cycles);
        end
        n_checks++;
        if (vbad != 0) begin
            n_fail++;
            $display("FAIL %s_vec_seq: %0d cycles with wrong vec_out, required 0", name, vbad);
        end
        n_checks++;
        if (ia.done !== 1'b1 || ia.err_count !== 3'(e.err) || ia.pass !== e.pass) begin
            n_fail++;
            $display("FAIL %s_result: done=%b err=%0d pass=%b required 1 %0d %b",
                     name, ia.done, ia.err_count, ia.pass, e.err, e.pass);
        end
        n_checks++;
        if (ia.fail_valid !== e.fv || (e.fv && ia.fail_vec !== 2'(e.fvec))) begin
            n_fail++;
            $display("FAIL %s_first_fail: fv=%b fvec=%0d required %b %0d",
                     name, ia.fail_valid, ia.fail_vec, e.fv, e.fvec);
        end
        $display("%s: cycles=%0d err=%0d pass=%b fv=%b fvec=%0d",
                 name, cyc, ia.err_count, ia.pass, ia.fail_valid, ia.fail_vec);
    endtask

    task automatic test_nand();     run_a(0, 1'b0, "nand");     endtask
    task automatic test_and_gate(); run_a(1, 1'b0, "and");      endtask
    task automatic test_stuck1();   run_a(2, 1'b0, "stuck1");   endtask

    // Mid-sweep starts are ignored; a start from DONE restarts immediately.
    task automatic test_back_to_back();
        run_a(0, 1'b1, "pulses");
        run_a(1, 1'b0, "b2b_and");
        run_a(0, 1'b0, "b2b_nand");
    endtask

    task automatic test_reset_mid();
        int k;
        mode_a = 0;
        @(negedge clk);
        ia.start = 1'b1;
        @(posedge clk);
        #1 ia.start = 1'b0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ia.vec_out == 2'd2) break;
        end
        n_checks++;
        if (k == 50) begin
            n_fail++;
            $display("FAIL rst_mid_wait: vec_out never reached 2");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ia.vec_out, ia.busy, ia.done, ia.pass, ia.err_count, ia.fail_valid, ia.fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got vec=%0d busy=%b done=%b err=%0d required all 0",
                     ia.vec_out, ia.busy, ia.done, ia.err_count);
        end
        $display("rst_mid: abandoned at vec 2");
        rst = 1'b0;
        run_a(0, 1'b0, "after_rst");
    endtask

    task automatic test_settle0();
        logic [7:0] ys;
        exp_t e;
        int cyc, vbad;
        mode_b = 0;
        ys = '0;
        for (int v = 0; v < 4; v++) ys[v] = gate2(0, 2'(v));
        sb.push_back(model(2, 0, 8'(NAND_TT), ys));
        @(negedge clk);
        ib.start = 1'b1;
        @(posedge clk);
        #1 ib.start = 1'b0;
        cyc = 0; vbad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ib.busy) break;
            if (ib.vec_out !== 2'(cyc)) vbad++;
            cyc++;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc != e.cycles || vbad != 0) begin
            n_fail++;
            $display("FAIL settle0_timing: cycles=%0d badvec=%0d required %0d 0", cyc, vbad, e.cycles);
        end
        n_checks++;
        if (ib.done !== 1'b1 || ib.pass !== e.pass || ib.err_count !== 3'(e.err)) begin
            n_fail++;
            $display("FAIL settle0_result: done=%b pass=%b err=%0d required 1 %b %0d",
                     ib.done, ib.pass, ib.err_count, e.pass, e.err);
        end
        $display("settle0: cycles=%0d err=%0d pass=%b", cyc, ib.err_count, ib.pass);
    endtask

    task automatic run_c(input int mode, input string name);
        logic [7:0] ys;
        exp_t e;
        int cyc, vbad;
        mode_c = mode;
        for (int v = 0; v < 8; v++) ys[v] = gate3(mode, 3'(v));
        sb.push_back(model(3, 0, 8'h96, ys));
        @(negedge clk);
        ic.start = 1'b1;
        @(posedge clk);
        #1 ic.start = 1'b0;
        cyc = 0; vbad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!ic.busy) break;
            if (ic.vec_out !== 3'(cyc)) vbad++;
            cyc++;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc != e.cycles || vbad != 0) begin
            n_fail++;
            $display("FAIL %s_timing: cycles=%0d badvec=%0d required %0d 0", name, cyc, vbad, e.cycles);
        end
        n_checks++;
        if (ic.done !== 1'b1 || ic.pass !== e.pass || ic.err_count !== 4'(e.err)
            || ic.fail_valid !== e.fv || (e.fv && ic.fail_vec !== 3'(e.fvec))) begin
            n_fail++;
            $display("FAIL %s_result: done=%b pass=%b err=%0d fv=%b fvec=%0d required 1 %b %0d %b %0d",
                     name, ic.done, ic.pass, ic.err_count, ic.fail_valid, ic.fail_vec,
                     e.pass, e.err, e.fv, e.fvec);
        end
        $display("%s: cycles=%0d err=%0d pass=%b fvec=%0d", name, cyc, ic.err_count, ic.pass, ic.fail_vec);
    endtask

    task automatic test_n3();
        run_c(0, "n3_parity");
        run_c(1, "n3_all_bad");
    endtask

    initial begin
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        rst = 1'b1;
        test_reset();
        test_nand();
        test_and_gate();
        test_stuck1();
        test_back_to_back();
        test_reset_mid();
        test_settle0();
        test_n3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
